// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// Flush bubbles the stage and presents the exception handler PC; stall_cnt counts back-pressured cycles.
module pipe_stage_skid #(
    parameter int              DATA_W     = 96,
    parameter int              PC_W       = 32,
    parameter int              EXC_W      = 5,
    parameter logic [PC_W-1:0] HANDLER_PC = PC_W'(32'h0000_4180),
    parameter int              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_excode,
    input  logic              in_bd,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_excode,
    output logic              out_bd,

    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  excode;
        logic              bd;
    } beat_t;

    // Bit 0 is "main valid", bit 1 is "skid valid", so both handshake outputs are plain flop bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state;
    state_t state_next;

    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;

    logic   in_fire;
    logic   out_fire;
    logic   load_main_in;
    logic   load_main_skid;
    logic   load_skid;

    assign in_beat   = '{pc: in_pc, data: in_data, excode: in_excode, bd: in_bd};

    assign in_ready  = ~state[1];
    assign out_valid = state[0];

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b11: load_main_in = 1'b1;
                    2'b10: begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end
                    2'b01: state_next = EMPTY;
                    default: state_next = ONE;
                endcase
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the skid payload is cleared on reset/flush too, keeping it deterministic when it is promoted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= '{pc: HANDLER_PC, default: '0};
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

    // Flush does not clear the counter: a stall in the flush cycle still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_pc     = main_q.pc;
    assign out_data   = main_q.data;
    assign out_excode = main_q.excode;
    assign out_bd     = main_q.bd;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a FIFO model of capacity two predicts every output;
// a second instance with CNT_W=4 exercises stall counter saturation.
module tb_pipe_stage_skid;

    localparam int          DATA_W  = 96;
    localparam int          PC_W    = 32;
    localparam int          EXC_W   = 5;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  excode;
        logic              bd;
    } beat_t;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [PC_W-1:0]   in_pc     = '0;
    logic [DATA_W-1:0] in_data   = '0;
    logic [EXC_W-1:0]  in_excode = '0;
    logic              in_bd     = 1'b0;

    logic              in_ready,  in_ready4;
    logic              out_valid, out_valid4;
    logic [PC_W-1:0]   out_pc,    out_pc4;
    logic [DATA_W-1:0] out_data,  out_data4;
    logic [EXC_W-1:0]  out_excode, out_excode4;
    logic              out_bd,    out_bd4;
    logic [15:0]       stall_cnt;
    logic [3:0]        stall_cnt4;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_excode(in_excode), .in_bd(in_bd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_excode(out_excode), .out_bd(out_bd),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_pc(in_pc), .in_data(in_data), .in_excode(in_excode), .in_bd(in_bd),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_pc(out_pc4), .out_data(out_data4), .out_excode(out_excode4), .out_bd(out_bd4),
        .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;

    beat_t q[$];
    beat_t hold     = '0;
    beat_t exp_beat = '0;
    bit    exp_valid = 1'b0;
    bit    exp_rdy   = 1'b1;
    int    cnt16     = 0;
    int    cnt4      = 0;
    bit    armed     = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares outputs 2 units after the edge, retires beats just before the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            exp_valid = (q.size() > 0);
            exp_rdy   = (q.size() < 2);
            exp_beat  = exp_valid ? q[0] : hold;
            if (armed) begin
                check("out_valid",  160'(out_valid),  160'(exp_valid));
                check("in_ready",   160'(in_ready),   160'(exp_rdy));
                check("out_pc",     160'(out_pc),     160'(exp_beat.pc));
                check("out_data",   160'(out_data),   160'(exp_beat.data));
                check("out_excode", 160'(out_excode), 160'(exp_beat.excode));
                check("out_bd",     160'(out_bd),     160'(exp_beat.bd));
                check("stall_cnt",  160'(stall_cnt),  160'(cnt16));
                check("dut4_ctrl",  160'({out_valid4, in_ready4}), 160'({exp_valid, exp_rdy}));
                check("dut4_beat",  160'({out_pc4, out_data4, out_excode4, out_bd4}), 160'(exp_beat));
                check("stall_cnt4", 160'(stall_cnt4), 160'(cnt4));
            end
            #5;
            if (exp_valid && out_ready) begin
                hold = q.pop_front();
            end
            if (exp_valid && !out_ready) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15) cnt4++;
            end
            if (reset) begin
                q.delete();
                hold  = '0;
                cnt16 = 0;
                cnt4  = 0;
                armed = 1'b1;
            end else if (flush) begin
                q.delete();
                hold = '{pc: HANDLER, default: '0};
            end
        end
    end

    // One cycle of stimulus: drive at +4, probe in_ready against an out_ready toggle, push accepted beat at +8.
    task automatic drive(input bit v, input bit rdy, input bit fl, input bit rst, input logic [31:0] pc);
        logic ir;
        @(posedge clk);
        #4;
        in_valid  = v;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        in_pc     = pc;
        in_data   = {$urandom, $urandom, $urandom};
        in_excode = 5'($urandom);
        in_bd     = 1'($urandom);
        #1;
        ir        = in_ready;
        out_ready = ~rdy;
        #1;
        if (armed) check("in_ready_comb", 160'(in_ready), 160'(ir));
        out_ready = rdy;
        #2;
        if (v && exp_rdy && !fl && !rst) begin
            q.push_back('{pc: in_pc, data: in_data, excode: in_excode, bd: in_bd});
        end
    endtask

    initial begin
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        // Streaming at full rate
        drive(1, 1, 0, 0, 32'h3000);
        drive(1, 1, 0, 0, 32'h3004);
        drive(1, 1, 0, 0, 32'h3008);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // Back-pressure into FULL, then drain
        drive(1, 0, 0, 0, 32'h3000);
        drive(1, 0, 0, 0, 32'h3004);
        drive(1, 0, 0, 0, 32'h3010);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // Flush while FULL, then accept immediately afterwards
        drive(1, 0, 0, 0, 32'h3000);
        drive(1, 0, 0, 0, 32'h3004);
        drive(1, 0, 1, 0, 32'h300C);
        drive(1, 1, 0, 0, 32'h3010);
        drive(0, 1, 0, 0, 0);

        // Flush in ONE with simultaneous accept and emit
        drive(1, 0, 0, 0, 32'h3020);
        drive(1, 1, 1, 0, 32'h3024);
        drive(0, 1, 0, 0, 0);

        // Reset and flush together
        drive(1, 0, 0, 0, 32'h3030);
        drive(1, 0, 0, 0, 32'h3034);
        drive(1, 0, 1, 1, 32'h3038);
        drive(0, 0, 0, 0, 0);

        // Counter saturation on the CNT_W=4 instance
        drive(1, 0, 0, 0, 32'h3040);
        repeat (22) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 10000; i++) begin
            bit v, r, f, rs;
            v  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 63) == 0);
            rs = ($urandom_range(0, 1023) == 0);
            drive(v, r, f, rs, $urandom);
        end

        repeat (4) drive(0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
